fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the decode/execute datapath. Owns the program counter, issues reads to the synchronous instruction memory, and buffers returned instructions with their PCs in a small prefetch FIFO. Delivers them to decode over a valid/ready handshake. Supports branch redirect with full flush, including discarding any in-flight read.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 70 +++++++
 rtl/fetch_unit.sv | 140 ++++++++++++++
 tb/tb_fetch_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the fetch stage.
//   PC_W / INSTR_W : program counter and instruction widths
//   fetch_state_e  : fetch FSM states (BOOT, RUN, REDIRECT)
//   fetch_entry_t  : prefetch FIFO entry {pc, instr}
//   ENTRY_W        : packed width of one FIFO entry
package cpu_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  localparam int ENTRY_W = PC_W + INSTR_W;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO holding fetched instructions.
// Parameters: DEPTH (power of two, >= 2), WIDTH (entry width).
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   push_i, data_i     write an entry at the tail
//   pop_i              remove the head entry (ignored when empty)
//   flush_i            discard all entries; overrides push and pop
//   head_o             head entry, read straight from the storage registers
//   count_o            number of valid entries (0..DEPTH)
//   full_o, empty_o    occupancy flags
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic [WIDTH-1:0]       head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_pop;

  assign do_pop  = pop_i & ~empty_o;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Storage and pointers. Storage is cleared on reset so the head output
  // reads as zero out of reset. Pointers wrap naturally at DEPTH.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // The upstream issue rule reserves a slot for every outstanding read.
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o && !flush_i));

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Owns the PC, issues reads to a synchronous instruction memory (data one
// cycle after the strobe), buffers {pc, instr} in a prefetch FIFO and hands
// the head to decode over valid/ready. A redirect flushes everything.
// Optional feature macro: FETCH_PERF_EN adds stall_cnt_o / flush_cnt_o.
// Ports:
//   clk_i, rst_ni                   clock, asynchronous active-low reset
//   fetch_en_i                      allows new memory requests
//   imem_rd_en_o, imem_addr_o       memory read strobe / address
//   imem_rdata_i                    memory read data (cycle after strobe)
//   instr_valid_o, instr_ready_i    decode handshake
//   instr_o, instr_pc_o             head instruction and its PC
//   redirect_valid_i, redirect_pc_i branch redirect
//   stall_cnt_o, flush_cnt_o        (FETCH_PERF_EN) saturating counters
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               fetch_en_i,
  output logic               imem_rd_en_o,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    instr_pc_o,
  input  logic               redirect_valid_i,
  input  logic [PC_W-1:0]    redirect_pc_i
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]        stall_cnt_o,
  output logic [15:0]        flush_cnt_o
`endif
);

  fetch_state_e           state_q;
  logic [PC_W-1:0]        pc_q;
  logic [PC_W-1:0]        pc_d;
  logic [PC_W-1:0]        req_pc_q;
  logic                   inflight_q;
  logic                   issue;
  logic                   push;
  logic                   pop;
  fetch_entry_t           push_entry;
  fetch_entry_t           head_entry;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;

  // A slot is reserved for the read already in flight, so a new request is
  // only made when the FIFO can absorb both responses.
  assign issue = fetch_en_i & ~redirect_valid_i & (state_q == RUN) & ~fifo_full &
                 ((int'(fifo_count) + int'(inflight_q)) < DEPTH);

  // A response returning during a redirect belongs to the old stream and is
  // dropped. No request is issued in a redirect cycle, so clearing the
  // in-flight flag there leaves nothing stale behind.
  assign push       = inflight_q & ~redirect_valid_i;
  assign push_entry = '{pc: req_pc_q, instr: imem_rdata_i};

  assign instr_valid_o = ~fifo_empty & ~redirect_valid_i;
  assign pop           = instr_valid_o & instr_ready_i;
  assign instr_o       = head_entry.instr;
  assign instr_pc_o    = head_entry.pc;

  assign imem_rd_en_o = issue;
  assign imem_addr_o  = pc_q;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid_i) pc_d = redirect_pc_i;
    else if (issue)       pc_d = pc_q + 1'b1;
  end

  // Fetch FSM with PC and in-flight tracking.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= issue;
      if (issue) req_pc_q <= pc_q;
      if (redirect_valid_i) begin
        state_q <= REDIRECT;
      end else begin
        case (state_q)
          BOOT:     state_q <= RUN;
          RUN:      state_q <= RUN;
          REDIRECT: state_q <= RUN;
          default:  state_q <= BOOT;
        endcase
      end
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (push),
    .data_i (push_entry),
    .pop_i  (pop),
    .flush_i(redirect_valid_i),
    .head_o (head_entry),
    .count_o(fifo_count),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

`ifdef FETCH_PERF_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  // Saturating stall/flush counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (instr_valid_o && !instr_ready_i && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (redirect_valid_i && (flush_cnt_q != 16'hFFFF))
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed, table-driven bench for fetch_unit.
// Two instances share stimulus: dutA with RESET_PC=8'h00 and dutB with
// RESET_PC=8'hFE (exercises PC wrap). Each has its own memory model that
// returns 16'h1000 + addr one cycle after a read strobe.
module tb_fetch_unit;

  typedef struct {
    logic       fetchEn;
    logic       ready;
    logic       redirect;
    logic [7:0] redirectPc;
    logic       expRdEn;
    logic [7:0] expAddr;
    logic       expValid;
    logic       chkHead;
    logic [7:0] expPc;
  } vec_t;

  logic        clk;
  logic        rstN;
  logic        fetchEn;
  logic        instrReady;
  logic        redirectValid;
  logic [7:0]  redirectPc;

  logic        rdEnA, rdEnB;
  logic [7:0]  addrA, addrB;
  logic [15:0] rdataA, rdataB;
  logic        validA, validB;
  logic [15:0] instrA, instrB;
  logic [7:0]  pcA, pcB;
`ifdef FETCH_PERF_EN
  logic [15:0] stallA, flushA, stallB, flushB;
`endif

  int testsRun = 0;
  int testsFailed = 0;
  vec_t vecs[40];

  fetch_unit #(.DEPTH(4), .RESET_PC(8'h00)) dutA (
    .clk_i(clk), .rst_ni(rstN), .fetch_en_i(fetchEn),
    .imem_rd_en_o(rdEnA), .imem_addr_o(addrA), .imem_rdata_i(rdataA),
    .instr_valid_o(validA), .instr_ready_i(instrReady),
    .instr_o(instrA), .instr_pc_o(pcA),
    .redirect_valid_i(redirectValid), .redirect_pc_i(redirectPc)
`ifdef FETCH_PERF_EN
    , .stall_cnt_o(stallA), .flush_cnt_o(flushA)
`endif
  );

  fetch_unit #(.DEPTH(4), .RESET_PC(8'hFE)) dutB (
    .clk_i(clk), .rst_ni(rstN), .fetch_en_i(fetchEn),
    .imem_rd_en_o(rdEnB), .imem_addr_o(addrB), .imem_rdata_i(rdataB),
    .instr_valid_o(validB), .instr_ready_i(instrReady),
    .instr_o(instrB), .instr_pc_o(pcB),
    .redirect_valid_i(redirectValid), .redirect_pc_i(redirectPc)
`ifdef FETCH_PERF_EN
    , .stall_cnt_o(stallB), .flush_cnt_o(flushB)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memories.
  always @(posedge clk) begin
    if (rdEnA) rdataA <= 16'h1000 + {8'h00, addrA};
    if (rdEnB) rdataB <= 16'h1000 + {8'h00, addrB};
  end

  function automatic vec_t mkVec(input logic fe, input logic rdy, input logic rdr,
                                 input logic [7:0] rpc, input logic erd,
                                 input logic [7:0] eaddr, input logic ev,
                                 input logic ch, input logic [7:0] epc);
    vec_t v;
    v.fetchEn = fe; v.ready = rdy; v.redirect = rdr; v.redirectPc = rpc;
    v.expRdEn = erd; v.expAddr = eaddr; v.expValid = ev; v.chkHead = ch;
    v.expPc = epc;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    fetchEn       = v.fetchEn;
    instrReady    = v.ready;
    redirectValid = v.redirect;
    redirectPc    = v.redirectPc;
    #1;
  endtask

  // Apply vectors lo..hi; dutB is checked while its stream is a pure
  // offset (-2) of dutA's, i.e. before the absolute redirect target.
  task automatic runVectors(input int lo, input int hi);
    logic [7:0] pcOff;
    for (int i = lo; i <= hi; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("step%0d rd_en", i), {15'd0, rdEnA}, {15'd0, vecs[i].expRdEn});
      checkOutput($sformatf("step%0d addr", i), {8'd0, addrA}, {8'd0, vecs[i].expAddr});
      checkOutput($sformatf("step%0d valid", i), {15'd0, validA}, {15'd0, vecs[i].expValid});
      if (vecs[i].chkHead) begin
        checkOutput($sformatf("step%0d instr_pc", i), {8'd0, pcA}, {8'd0, vecs[i].expPc});
        checkOutput($sformatf("step%0d instr", i), instrA, 16'h1000 + {8'd0, vecs[i].expPc});
      end
      if (i < 32) begin
        pcOff = vecs[i].expAddr + 8'hFE;
        checkOutput($sformatf("step%0d B addr", i), {8'd0, addrB}, {8'd0, pcOff});
        checkOutput($sformatf("step%0d B valid", i), {15'd0, validB}, {15'd0, vecs[i].expValid});
        if (vecs[i].chkHead) begin
          pcOff = vecs[i].expPc + 8'hFE;
          checkOutput($sformatf("step%0d B instr_pc", i), {8'd0, pcB}, {8'd0, pcOff});
          checkOutput($sformatf("step%0d B instr", i), instrB, 16'h1000 + {8'd0, pcOff});
        end
      end
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " rd_en"}, {15'd0, rdEnA}, 16'h0000);
    checkOutput({tag, " addr"}, {8'd0, addrA}, 16'h0000);
    checkOutput({tag, " B addr"}, {8'd0, addrB}, 16'h00FE);
    checkOutput({tag, " valid"}, {15'd0, validA}, 16'h0000);
    checkOutput({tag, " instr"}, instrA, 16'h0000);
    checkOutput({tag, " instr_pc"}, {8'd0, pcA}, 16'h0000);
`ifdef FETCH_PERF_EN
    checkOutput({tag, " stall_cnt"}, stallA, 16'h0000);
    checkOutput({tag, " flush_cnt"}, flushA, 16'h0000);
`endif
  endtask

  initial begin
    // fe rdy redir rpc | rd_en addr valid chkHead pc
    vecs[0]  = mkVec(1, 1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00);
    vecs[1]  = mkVec(1, 1, 0, 8'h00, 1, 8'h00, 0, 0, 8'h00);
    vecs[2]  = mkVec(1, 1, 0, 8'h00, 1, 8'h01, 0, 0, 8'h00);
    vecs[3]  = mkVec(1, 1, 0, 8'h00, 1, 8'h02, 1, 1, 8'h00);
    vecs[4]  = mkVec(1, 1, 0, 8'h00, 1, 8'h03, 1, 1, 8'h01);
    vecs[5]  = mkVec(1, 1, 0, 8'h00, 1, 8'h04, 1, 1, 8'h02);
    vecs[6]  = mkVec(1, 0, 0, 8'h00, 1, 8'h05, 1, 1, 8'h03);
    vecs[7]  = mkVec(1, 0, 0, 8'h00, 1, 8'h06, 1, 1, 8'h03);
    for (int i = 8; i <= 15; i++) vecs[i] = mkVec(1, 0, 0, 8'h00, 0, 8'h07, 1, 1, 8'h03);
    vecs[16] = mkVec(1, 1, 0, 8'h00, 0, 8'h07, 1, 1, 8'h03);
    vecs[17] = mkVec(1, 1, 0, 8'h00, 1, 8'h07, 1, 1, 8'h04);
    vecs[18] = mkVec(1, 1, 0, 8'h00, 1, 8'h08, 1, 1, 8'h05);
    vecs[19] = mkVec(1, 1, 0, 8'h00, 1, 8'h09, 1, 1, 8'h06);
    vecs[20] = mkVec(1, 1, 0, 8'h00, 1, 8'h0A, 1, 1, 8'h07);
    vecs[21] = mkVec(1, 1, 0, 8'h00, 1, 8'h0B, 1, 1, 8'h08);
    vecs[22] = mkVec(1, 1, 0, 8'h00, 1, 8'h0C, 1, 1, 8'h09);
    vecs[23] = mkVec(0, 1, 0, 8'h00, 0, 8'h0D, 1, 1, 8'h0A);
    vecs[24] = mkVec(0, 1, 0, 8'h00, 0, 8'h0D, 1, 1, 8'h0B);
    vecs[25] = mkVec(0, 1, 0, 8'h00, 0, 8'h0D, 1, 1, 8'h0C);
    vecs[26] = mkVec(0, 0, 0, 8'h00, 0, 8'h0D, 0, 0, 8'h00);
    vecs[27] = mkVec(0, 0, 0, 8'h00, 0, 8'h0D, 0, 0, 8'h00);
    vecs[28] = mkVec(1, 0, 0, 8'h00, 1, 8'h0D, 0, 0, 8'h00);
    vecs[29] = mkVec(1, 0, 0, 8'h00, 1, 8'h0E, 0, 0, 8'h00);
    vecs[30] = mkVec(1, 0, 0, 8'h00, 1, 8'h0F, 1, 1, 8'h0D);
    vecs[31] = mkVec(1, 0, 0, 8'h00, 1, 8'h10, 1, 1, 8'h0D);
    vecs[32] = mkVec(1, 0, 1, 8'h40, 0, 8'h11, 0, 0, 8'h00);
    vecs[33] = mkVec(1, 1, 0, 8'h00, 0, 8'h40, 0, 0, 8'h00);
    vecs[34] = mkVec(1, 1, 0, 8'h00, 1, 8'h40, 0, 0, 8'h00);
    vecs[35] = mkVec(1, 1, 0, 8'h00, 1, 8'h41, 0, 0, 8'h00);
    vecs[36] = mkVec(1, 1, 0, 8'h00, 1, 8'h42, 1, 1, 8'h40);
    vecs[37] = mkVec(1, 1, 0, 8'h00, 1, 8'h43, 1, 1, 8'h41);
    vecs[38] = mkVec(1, 0, 0, 8'h00, 1, 8'h44, 1, 1, 8'h42);
    vecs[39] = mkVec(1, 0, 0, 8'h00, 1, 8'h45, 1, 1, 8'h42);

    rstN          = 1'b0;
    fetchEn       = 1'b0;
    instrReady    = 1'b0;
    redirectValid = 1'b0;
    redirectPc    = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checkResetState("reset");
    #1;
    rstN = 1'b1;

    // Startup, backpressure fill/drain, fetch_en off, redirect.
    runVectors(0, 37);
`ifdef FETCH_PERF_EN
    checkOutput("stall_cnt", stallA, 16'd12);
    checkOutput("flush_cnt", flushA, 16'd1);
`endif

    // Build up two entries with a read in flight, then reset mid-cycle.
    runVectors(38, 39);
    #2;
    rstN = 1'b0;
    #1;
    checkResetState("mid reset");

    repeat (2) @(posedge clk);
    #2;
    rstN = 1'b1;
    runVectors(0, 6);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
